// File: rtl/mem_stage_access_pkg.sv
// Shared pipeline types for the memory stage: FSM encoding, widths, MEM/WB metadata.
// Pure declarations, no logic or timing.
package mem_stage_access_pkg;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam logic [DW-1:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [DW-1:0] alu_out;
        logic [RW-1:0] write_reg;
        logic          reg_write;
        logic          memto_reg;
    } meta_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; 1-cycle latency.
// A stalled M stage inserts a bubble (control bits cleared, data fields hold).
module mem_wb_reg
    import mem_stage_access_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          done,
    input  logic          is_load,
    input  logic [DW-1:0] rdata_buf,
    input  logic          err_buf,
    input  meta_t         meta_m,
    output meta_t         meta_w,
    output logic [DW-1:0] ReadDataW,
    output logic          MemErrW
);

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_w    <= '0;
            ReadDataW <= '0;
            MemErrW   <= 1'b0;
        end else if (stall) begin
            meta_w.reg_write <= 1'b0;
            meta_w.memto_reg <= 1'b0;
            MemErrW          <= 1'b0;
        end else begin
            meta_w    <= meta_m;
            ReadDataW <= (done && is_load) ? rdata_buf : '0;
            MemErrW   <= done & err_buf;
        end
    end

endmodule

// File: rtl/mem_stage_access.sv
// Memory stage: req/ack data-memory access with timeout, feeding the MEM/WB register.
// Memory ops occupy M for >=3 cycles; StallM freezes upstream until the DONE cycle.
module mem_stage_access
    import mem_stage_access_pkg::*;
#(
    parameter int            TIMEOUT  = 16,
    parameter logic [DW-1:0] ERR_DATA = ERR_DATA_DEF
)
(
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] ALUOutM,
    input  logic [DW-1:0] WriteDataM,
    input  logic [RW-1:0] WriteRegM,
    input  logic          RegWriteM,
    input  logic          MemtoRegM,
    input  logic          MemWriteM,
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          StallM,
    output logic [DW-1:0] ALUOutW,
    output logic [DW-1:0] ReadDataW,
    output logic [RW-1:0] WriteRegW,
    output logic          RegWriteW,
    output logic          MemtoRegW,
    output logic          MemErrW
);

    localparam int CW = $clog2(TIMEOUT);

    state_t        state, state_nxt;
    logic [CW-1:0] wait_cnt;
    logic [DW-1:0] rdata_buf;
    logic          err_buf;
    logic          access, is_load, in_wait, in_done, cnt_last, timeout_hit;
    meta_t         meta_m, meta_w;

    assign access      = MemtoRegM | MemWriteM;
    // A combined load+store flag is handled as a store.
    assign is_load     = MemtoRegM & ~MemWriteM;
    assign in_wait     = (state == S_WAIT);
    assign in_done     = (state == S_DONE);
    assign cnt_last    = (wait_cnt == CW'(TIMEOUT - 1));
    assign timeout_hit = in_wait & ~mem_ack & cnt_last;

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        StallM    = 1'b0;
        case (state)
            S_IDLE: begin
                if (access) begin
                    state_nxt = S_WAIT;
                    mem_req   = 1'b1;
                    StallM    = 1'b1;
                end
            end
            S_WAIT: begin
                mem_req = 1'b1;
                StallM  = 1'b1;
                if (mem_ack || cnt_last) begin
                    state_nxt = S_DONE;
                end
            end
            // DONE drops the stall so EX/MEM advances and the op is not reissued.
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign mem_we    = MemWriteM & mem_req;
    assign mem_addr  = {ALUOutM[DW-1:2], 2'b00};
    assign mem_wdata = WriteDataM;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Ack outside WAIT is a stale response and is deliberately ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt  <= '0;
            rdata_buf <= '0;
            err_buf   <= 1'b0;
        end else if (state == S_IDLE && access) begin
            wait_cnt <= '0;
            err_buf  <= 1'b0;
        end else if (in_wait) begin
            wait_cnt <= wait_cnt + 1'b1;
            if (mem_ack) begin
                err_buf <= 1'b0;
                if (is_load) begin
                    rdata_buf <= mem_rdata;
                end
            end else if (timeout_hit) begin
                rdata_buf <= ERR_DATA;
                err_buf   <= 1'b1;
            end
        end
    end

    assign meta_m = '{alu_out:   ALUOutM,
                      write_reg: WriteRegM,
                      reg_write: RegWriteM,
                      memto_reg: MemtoRegM};

    mem_wb_reg u_mem_wb_reg (
        .clk       (clk),
        .reset     (reset),
        .stall     (StallM),
        .done      (in_done),
        .is_load   (is_load),
        .rdata_buf (rdata_buf),
        .err_buf   (err_buf),
        .meta_m    (meta_m),
        .meta_w    (meta_w),
        .ReadDataW (ReadDataW),
        .MemErrW   (MemErrW)
    );

    assign ALUOutW   = meta_w.alu_out;
    assign WriteRegW = meta_w.write_reg;
    assign RegWriteW = meta_w.reg_write;
    assign MemtoRegW = meta_w.memto_reg;

endmodule
